// File: rtl/e_mdu_if.sv
// Operand, control and result signals between the Execute stage and the
// multiply/divide unit. The pipeline drives operands through the master
// modport, and the MDU (slave) returns busy and the HI/LO values.
interface e_mdu_if;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic [2:0]  md_op;
  logic        mf_sel;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] E_HILO;

  modport master (
    output E_rs, E_rt, md_op, mf_sel,
    input  busy, HI, LO, E_HILO
  );

  modport slave (
    input  E_rs, E_rt, md_op, mf_sel,
    output busy, HI, LO, E_HILO
  );
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit. It owns the architectural HI/LO
// registers. The result of a mult/div is computed when the operation is
// accepted and held in pend_hi/pend_lo. It is committed to HI/LO when a
// fixed-length countdown expires, so the visible latency is MULT_CYCLES
// or DIV_CYCLES regardless of operand values.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic   clk,
  input logic   reset,
  e_mdu_if.slave bus
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        no_write_q;   // current divide had a zero divisor

  md_op_e      op;
  logic [31:0] a, b, b_safe;
  logic [63:0] prod_s, prod_u;
  logic        div_by_zero;
  logic [31:0] quo_u, rem_u;
  logic [31:0] mag_a, mag_b, q_mag, r_mag;
  logic [31:0] quo_s, rem_s;

  // Combinational datapath: products and quotients of the current operands.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    op          = md_op_e'(bus.md_op);
    a           = bus.E_rs;
    b           = bus.E_rt;
    div_by_zero = (b == 32'd0);
    // A zero divisor is replaced with 1. The result is never committed, and
    // this keeps the divider free of X and undefined values.
    b_safe      = div_by_zero ? 32'd1 : b;

    prod_u = {32'd0, a} * {32'd0, b};
    // The low 64 bits of the sign-extended product equal the signed product.
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

    quo_u = a / b_safe;
    rem_u = a % b_safe;

    // Signed divide runs on magnitudes and then fixes the signs. The quotient
    // truncates toward zero, and the remainder follows the sign of the
    // dividend. 0x80000000 / -1 wraps back to 0x80000000.
    mag_a = a[31]      ? -a      : a;
    mag_b = b_safe[31] ? -b_safe : b_safe;
    q_mag = mag_a / mag_b;
    r_mag = mag_a % mag_b;
    quo_s = (a[31] ^ b_safe[31]) ? -q_mag : q_mag;
    rem_s = a[31] ? -r_mag : r_mag;
  end

  // State: accept an op when idle, count down while busy, commit on the last count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the pending result registers are cleared too, so an operation
      // interrupted by reset leaves nothing stale behind.
      hi_q       <= '0;
      lo_q       <= '0;
      pend_hi_q  <= '0;
      pend_lo_q  <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      no_write_q <= 1'b0;
    end else if (busy_q) begin
      // NOTE: non-blocking assignments let every register see pre-edge values.
      if (cnt_q == 4'd1) begin
        if (!no_write_q) begin
          hi_q <= pend_hi_q;
          lo_q <= pend_lo_q;
        end
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 4'd1;
      end
    end else begin
      unique case (op)
        OP_MULT: begin
          {pend_hi_q, pend_lo_q} <= prod_s;
          cnt_q      <= 4'(MULT_CYCLES);
          busy_q     <= 1'b1;
          no_write_q <= 1'b0;
        end
        OP_MULTU: begin
          {pend_hi_q, pend_lo_q} <= prod_u;
          cnt_q      <= 4'(MULT_CYCLES);
          busy_q     <= 1'b1;
          no_write_q <= 1'b0;
        end
        OP_DIV: begin
          pend_lo_q  <= quo_s;
          pend_hi_q  <= rem_s;
          cnt_q      <= 4'(DIV_CYCLES);
          busy_q     <= 1'b1;
          no_write_q <= div_by_zero;
        end
        OP_DIVU: begin
          pend_lo_q  <= quo_u;
          pend_hi_q  <= rem_u;
          cnt_q      <= 4'(DIV_CYCLES);
          busy_q     <= 1'b1;
          no_write_q <= div_by_zero;
        end
        OP_MTHI: hi_q <= a;
        OP_MTLO: lo_q <= a;
        default: ;  // OP_NONE and OP_RSVD do nothing
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.HI     = hi_q;
  assign bus.LO     = lo_q;
  assign bus.E_HILO = bus.mf_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu. It covers reset, mthi/mtlo, signed and unsigned
// multiply and divide, divide by zero, ops that arrive while busy, and reset
// in the middle of an operation.
module tb_e_mdu;

  localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2,
                         OP_DIV = 3'd3, OP_DIVU = 3'd4, OP_MTHI = 3'd5,
                         OP_MTLO = 3'd6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] val);
    bus.md_op = op;
    bus.E_rs  = val;
    step();
    bus.md_op = OP_NONE;
  endtask

  // Issue one op. Return how many cycles busy stayed high and whether HI/LO
  // held their values while it did. With inject set, an mtlo 0x55 is driven
  // during busy cycle 2.
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input bit inject, output int cycles, output bit held);
    logic [31:0] hi0, lo0;
    hi0 = bus.HI;
    lo0 = bus.LO;
    bus.md_op = op;
    bus.E_rs  = rs;
    bus.E_rt  = rt;
    step();
    bus.md_op = OP_NONE;
    cycles = 0;
    held = 1'b1;
    while (bus.busy === 1'b1 && cycles < 40) begin
      cycles++;
      if (bus.HI !== hi0 || bus.LO !== lo0) held = 1'b0;
      if (inject && cycles == 2) begin
        bus.md_op = OP_MTLO;
        bus.E_rs  = 32'h55;
      end else begin
        bus.md_op = OP_NONE;
      end
      step();
    end
    bus.md_op = OP_NONE;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.md_op = OP_NONE; bus.E_rs = '0; bus.E_rt = '0; bus.mf_sel = 1'b0;
    #3;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.HI !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", bus.HI); end
    n_checks++; if (bus.LO !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", bus.LO); end
    n_checks++; if (bus.E_HILO !== 32'h0) begin n_fail++; $display("FAIL reset_hilo: got %h expected 0", bus.E_HILO); end
    step();
    #2 reset = 1'b1;
    step();
  endtask

  task automatic test_mt();
    do_mt(OP_MTHI, 32'h12345678);
    n_checks++; if (bus.HI !== 32'h12345678) begin n_fail++; $display("FAIL mthi_hi: got %h expected 12345678", bus.HI); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b expected 0", bus.busy); end
    bus.mf_sel = 1'b0; #1;
    n_checks++; if (bus.E_HILO !== 32'h12345678) begin n_fail++; $display("FAIL mthi_hilo: got %h expected 12345678", bus.E_HILO); end
    do_mt(OP_MTLO, 32'h9ABCDEF0);
    n_checks++; if (bus.LO !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL mtlo_lo: got %h expected 9abcdef0", bus.LO); end
    n_checks++; if (bus.HI !== 32'h12345678) begin n_fail++; $display("FAIL mtlo_hi_kept: got %h expected 12345678", bus.HI); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy: got %b expected 0", bus.busy); end
    bus.mf_sel = 1'b1; #1;
    n_checks++; if (bus.E_HILO !== 32'h9ABCDEF0) begin n_fail++; $display("FAIL mtlo_hilo: got %h expected 9abcdef0", bus.E_HILO); end
  endtask

  task automatic test_mult();
    int cyc; bit held;
    run_op(OP_MULT, 32'hFFFFFFFF, 32'd2, 1'b0, cyc, held);
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL mult_cycles: got %0d expected 5", cyc); end
    n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL mult_hold: HI/LO changed while busy"); end
    n_checks++; if (bus.HI !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", bus.HI); end
    n_checks++; if (bus.LO !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffffe", bus.LO); end
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, cyc, held);
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL multu_cycles: got %0d expected 5", cyc); end
    n_checks++; if (bus.HI !== 32'h00000001) begin n_fail++; $display("FAIL multu_hi: got %h expected 00000001", bus.HI); end
    n_checks++; if (bus.LO !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_lo: got %h expected fffffffe", bus.LO); end
    bus.mf_sel = 1'b0; #1;
    n_checks++; if (bus.E_HILO !== 32'h00000001) begin n_fail++; $display("FAIL multu_hilo: got %h expected 00000001", bus.E_HILO); end
  endtask

  task automatic test_div();
    int cyc; bit held;
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, cyc, held);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL div_cycles: got %0d expected 10", cyc); end
    n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL div_hold: HI/LO changed while busy"); end
    n_checks++; if (bus.LO !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo: got %h expected fffffffd", bus.LO); end
    n_checks++; if (bus.HI !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi: got %h expected ffffffff", bus.HI); end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, cyc, held);
    n_checks++; if (bus.LO !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf_lo: got %h expected 80000000", bus.LO); end
    n_checks++; if (bus.HI !== 32'h00000000) begin n_fail++; $display("FAIL div_ovf_hi: got %h expected 00000000", bus.HI); end
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, cyc, held);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL divu_cycles: got %0d expected 10", cyc); end
    n_checks++; if (bus.LO !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h expected 0000000e", bus.LO); end
    n_checks++; if (bus.HI !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h expected 00000002", bus.HI); end
  endtask

  task automatic test_div_zero();
    int cyc; bit held;
    do_mt(OP_MTHI, 32'hAAAA0000);
    do_mt(OP_MTLO, 32'h0000BBBB);
    run_op(OP_DIVU, 32'd5, 32'd0, 1'b0, cyc, held);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL divz_cycles: got %0d expected 10", cyc); end
    n_checks++; if (bus.HI !== 32'hAAAA0000) begin n_fail++; $display("FAIL divz_hi: got %h expected aaaa0000", bus.HI); end
    n_checks++; if (bus.LO !== 32'h0000BBBB) begin n_fail++; $display("FAIL divz_lo: got %h expected 0000bbbb", bus.LO); end
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd0, 1'b0, cyc, held);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL divz_s_cycles: got %0d expected 10", cyc); end
    n_checks++; if (bus.LO !== 32'h0000BBBB) begin n_fail++; $display("FAIL divz_s_lo: got %h expected 0000bbbb", bus.LO); end
  endtask

  task automatic test_ignore_busy();
    int cyc; bit held;
    run_op(OP_MULT, 32'd3, 32'd4, 1'b1, cyc, held);
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL ign_cycles: got %0d expected 5", cyc); end
    n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL ign_hold: HI/LO changed while busy"); end
    n_checks++; if (bus.LO !== 32'd12) begin n_fail++; $display("FAIL ign_lo: got %h expected 0000000c", bus.LO); end
    n_checks++; if (bus.HI !== 32'd0) begin n_fail++; $display("FAIL ign_hi: got %h expected 00000000", bus.HI); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit held;
    // A mult issued on the cycle busy falls is accepted right away.
    run_op(OP_MULTU, 32'h00010000, 32'h00010000, 1'b0, cyc, held);
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL b2b_cycles: got %0d expected 5", cyc); end
    n_checks++; if (bus.HI !== 32'd1 || bus.LO !== 32'd0) begin n_fail++; $display("FAIL b2b_result: got %h_%h expected 00000001_00000000", bus.HI, bus.LO); end
  endtask

  task automatic test_reset_mid();
    do_mt(OP_MTHI, 32'h1111);
    do_mt(OP_MTLO, 32'h2222);
    bus.md_op = OP_DIV; bus.E_rs = 32'd7; bus.E_rt = 32'd2;
    step();
    bus.md_op = OP_NONE;
    repeat (3) step();
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b expected 1", bus.busy); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.HI !== 32'h0) begin n_fail++; $display("FAIL rmid_hi: got %h expected 0", bus.HI); end
    n_checks++; if (bus.LO !== 32'h0) begin n_fail++; $display("FAIL rmid_lo: got %h expected 0", bus.LO); end
    step();
    #2 reset = 1'b1;
    repeat (15) step();
    n_checks++; if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin n_fail++; $display("FAIL rmid_late: got %h_%h expected 00000000_00000000", bus.HI, bus.LO); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_after: got %b expected 0", bus.busy); end
    do_mt(OP_MTHI, 32'h77);
    n_checks++; if (bus.HI !== 32'h77) begin n_fail++; $display("FAIL rmid_accept: got %h expected 00000077", bus.HI); end
  endtask

  initial begin
    test_reset();
    test_mt();
    test_mult();
    test_div();
    test_div_zero();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit for the Execute stage of the five-stage MIPS pipeline. It owns the architectural HI/LO registers and runs mult, multu, div, divu, mthi and mtlo. Multiplies take a fixed 5 cycles and divides a fixed 10. It produces the HI/LO read value that the E/M pipeline register carries into Memory as E_HILO, and a busy flag that the hazard unit uses to stall dependent instructions in Decode.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low; reset low clears all state immediately
- E_rs  input  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
- E_rt  input  32  forwarded rt operand (divisor / multiplier)
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 treated as none
- mf_sel  input  1  0 selects HI, 1 selects LO, for E_HILO
- busy  output  1  registered; high while a multiply or divide is in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register
- E_HILO  output  32  combinational: mf_sel ? LO : HI

## Operation
- Internal state: HI, LO, pend_hi, pend_lo (32 bits each), cnt (4 bits), busy.
- An operation is accepted only when busy=0 at the sampling edge. md_op is ignored while busy=1. The hazard unit guarantees that no md instruction sits in E while busy=1, and any that does is dropped.
- mult: {pend_hi,pend_lo} <= signed 64-bit product of E_rs and E_rt. cnt <= MULT_CYCLES. busy <= 1.
- multu: same as mult, but the product is unsigned.
- div (signed):
  - pend_lo <= quotient, truncated toward zero.
  - pend_hi <= remainder, which takes the sign of the dividend.
  - cnt <= DIV_CYCLES. busy <= 1.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000 and HI=0.
- divu: unsigned quotient into pend_lo, unsigned remainder into pend_hi. Counter and busy as for div.
- Divide by zero (div or divu with E_rt=0):
  - busy and the counter run the full DIV_CYCLES.
  - On completion HI and LO keep their old values; no write occurs.
- mthi: HI <= E_rs at the sampling edge. mtlo: LO <= E_rs. Neither asserts busy.
- Countdown: while busy=1, each edge does cnt <= cnt-1. On the edge where cnt==1, the unit performs:
  - HI <= pend_hi and LO <= pend_lo (unless the operation was a divide by zero);
  - cnt <= 0 and busy <= 0.
- Results may be computed combinationally at acceptance and held in pend_*. Equivalently, an iterative datapath is allowed, provided the output timing below is identical.

## Timing
- Reset value (reset low, asynchronous): HI=0, LO=0, pend_hi=0, pend_lo=0, cnt=0, busy=0. E_HILO therefore reads 0.
- Start edge T0 samples md_op=mult:
  - busy is high for cycles T0..T0+4, i.e. 5 cycles.
  - HI/LO take the new values at edge T0+5, the same edge at which busy falls.
  - mfhi/mflo issued once busy=0 reads the new value.
- Divide: the same pattern with 10 busy cycles. HI/LO update at edge T0+10.
- mthi/mtlo: the new value is visible on HI/LO and E_HILO in the cycle after the sampling edge.
- While busy, HI/LO keep their old values and E_HILO reflects them.
- Stall interaction: the hazard unit stalls Decode when busy=1, or when md_op≠0 in E, and the instruction in Decode is mult/div/mf/mt.
- Reset asserted mid-operation: busy, cnt and HI/LO clear immediately. The pending result is discarded and is never written.
- Reset release: the first accepted md_op is at the first rising edge with reset=1.

## Test plan
- Reset then mthi/mtlo: drive reset low, then high. mthi with E_rs=0x12345678, then mtlo with E_rs=0x9ABCDEF0 → HI=0x12345678 and LO=0x9ABCDEF0 one cycle after each; busy stays 0 throughout.
- Signed versus unsigned multiply:
  - mult with E_rs=0xFFFFFFFF (−1), E_rt=2 → busy for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- Signed divide: div with E_rs=0xFFFFFFF9 (−7), E_rt=2 → busy for 10 cycles, then LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). The overflow case 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: preload HI=0xAAAA0000 and LO=0x0000BBBB, then divu with E_rt=0 → busy for 10 cycles, and HI/LO are unchanged afterwards.
- Ignore while busy: during mult cycle 2, drive md_op=mtlo with E_rs=0x55 → LO ends with the product result, not 0x55, and busy still falls after exactly 5 cycles.
- Reset mid-operation: start div 7/2 and pull reset low at cycle 4 → busy=0, HI=0 and LO=0 immediately. After release, HI and LO remain 0 with no late write.
